// File: rtl/stream_chunk_packer.sv
// -----------------------------------------------------------------------------
// stream_chunk_packer
//
// Packs IN_WIDTH-bit beats, MSB-first, into an OUT_WIDTH-bit frame. The frame
// is emitted either in stream order or with CHUNK_SIZE-bit chunks reversed
// (the same result as {<<CHUNK_SIZE{bits}} assigned to a wider target). A beat
// with in_last closes a partial frame, which is left-justified and zero-padded.
//
// Optional feature macro: STREAM_CHUNK_PACKER_COUNT_EN
//   When defined, adds out_beats, the number of beats in the held frame.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   beat offered
//   in_ready   out  beat accepted when in_valid && in_ready
//   in_data    in   beat payload [IN_WIDTH]
//   in_last    in   closes the frame after this beat
//   in_rev     in   0 = stream order, 1 = chunk-reversed (taken from beat 0)
//   out_valid  out  frame available
//   out_ready  in   frame consumed when out_valid && out_ready
//   out_data   out  packed frame [OUT_WIDTH]
//   out_beats  out  beats in frame [$clog2(BEATS+1)] (COUNT_EN builds only)
// -----------------------------------------------------------------------------
module stream_chunk_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 in_rev,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
    output logic [$clog2(OUT_WIDTH/IN_WIDTH+1)-1:0] out_beats,
`endif
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam int BEATS   = OUT_WIDTH / IN_WIDTH;
    localparam int CW      = $clog2(BEATS);
    localparam int BCW     = $clog2(BEATS + 1);
    localparam int NCHUNKS = OUT_WIDTH / CHUNK_SIZE;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          count_q;
    logic                   mode_q;
    logic [OUT_WIDTH-1:0]   acc_q;
    logic [OUT_WIDTH-1:0]   out_data_q;
    logic                   out_valid_q;
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
    logic [BCW-1:0]         out_beats_q;
`endif

    logic                   accept;
    logic                   close;
    logic                   beat_mode;
    logic [OUT_WIDTH-1:0]   merged;
    logic [OUT_WIDTH-1:0]   reversed;
    logic [OUT_WIDTH-1:0]   frame_d;

    // Bypass: a held frame draining this cycle frees the output register, so
    // the next beat may be accepted in the same cycle.
    assign in_ready  = (state_q == FILL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign close     = accept && (in_last || (count_q == CW'(BEATS - 1)));
    // Beat 0 uses the live in_rev; later beats use the captured mode.
    assign beat_mode = (count_q == '0) ? in_rev : mode_q;

    // Accumulator with the current beat merged into its lane. Lanes not yet
    // written are still zero because the accumulator clears on every close.
    always_comb begin
        merged = acc_q;
        merged[OUT_WIDTH - 1 - int'(count_q) * IN_WIDTH -: IN_WIDTH] = in_data;
    end

    // Chunk reversal of the top N valid bits: the least significant chunk of
    // the valid field lands at the MSBs; everything below N stays zero.
    always_comb begin
        int nbits;
        int nch;
        nbits    = (int'(count_q) + 1) * IN_WIDTH;
        nch      = nbits / CHUNK_SIZE;
        reversed = '0;
        for (int j = 0; j < NCHUNKS; j++) begin
            if (j < nch) begin
                reversed[OUT_WIDTH - 1 - j * CHUNK_SIZE -: CHUNK_SIZE] =
                    merged[OUT_WIDTH - nbits + j * CHUNK_SIZE +: CHUNK_SIZE];
            end
        end
    end

    assign frame_d = beat_mode ? reversed : merged;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
            out_beats_q <= '0;
`endif
        end else begin
            if (close) begin
                // Load the new frame; this also covers a 1-beat frame
                // arriving while the previous frame drains.
                state_q     <= FULL;
                out_valid_q <= 1'b1;
                out_data_q  <= frame_d;
                acc_q       <= '0;
                count_q     <= '0;
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
                out_beats_q <= BCW'(count_q) + BCW'(1);
`endif
            end else begin
                if (state_q == FULL && out_ready) begin
                    state_q     <= FILL;
                    out_valid_q <= 1'b0;
                end
                if (accept) begin
                    acc_q   <= merged;
                    count_q <= count_q + CW'(1);
                    if (count_q == '0) begin
                        mode_q <= in_rev;
                    end
                end
            end
            if (close && count_q == '0) begin
                mode_q <= in_rev;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
    assign out_beats = out_beats_q;
`endif

endmodule

// File: tb/tb_stream_chunk_packer.sv
module tb_stream_chunk_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_rev;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
    logic [2:0]  out_beats;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    stream_chunk_packer #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (32),
        .CHUNK_SIZE(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_rev   (in_rev),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
        .out_beats(out_beats),
`endif
        .out_data (out_data)
    );

    // Offer one beat and return 1 time unit after the edge that accepted it.
    // Entered 1 time unit after a rising edge.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic rev);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_rev   = rev;
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clock); #1;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clock); #1;
        $display("beat %h last=%0b rev=%0b accepted", d, last, rev);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_rev = 1'b0; out_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h required 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        reset = 1'b0;
        idle_cycle();
        $display("reset: out_valid=%0b out_data=%h in_ready=%0b", out_valid, out_data, in_ready);
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        send_beat(8'hA1, 1'b0, 1'b0);
        send_beat(8'hB2, 1'b0, 1'b0);
        send_beat(8'hC3, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %0b required 0", out_valid); end
        send_beat(8'hD4, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %0b required 1", out_valid); end
        checks++; if (out_data !== 32'hA1B2C3D4) begin errors++; $display("FAIL full_data: got %h required a1b2c3d4", out_data); end
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
        checks++; if (out_beats !== 3'd4) begin errors++; $display("FAIL full_beats: got %0d required 4", out_beats); end
`endif
        $display("full frame: out_data=%h", out_data);
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_reverse();
        out_ready = 1'b1;
        send_beat(8'hA1, 1'b0, 1'b1);
        send_beat(8'hB2, 1'b0, 1'b0);
        send_beat(8'hC3, 1'b0, 1'b1);
        send_beat(8'hD4, 1'b0, 1'b0);
        checks++; if (out_data !== 32'h4D3C2B1A) begin errors++; $display("FAIL rev_data: got %h required 4d3c2b1a", out_data); end
        $display("reverse frame: out_data=%h", out_data);
        idle_cycle();
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        send_beat(8'hA1, 1'b0, 1'b0);
        send_beat(8'hB2, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %0b required 1", out_valid); end
        checks++; if (out_data !== 32'hA1B20000) begin errors++; $display("FAIL partial_fwd: got %h required a1b20000", out_data); end
        $display("partial fwd: out_data=%h", out_data);
        idle_cycle();
        send_beat(8'hA1, 1'b0, 1'b1);
        send_beat(8'hB2, 1'b1, 1'b1);
        checks++; if (out_data !== 32'h2B1A0000) begin errors++; $display("FAIL partial_rev: got %h required 2b1a0000", out_data); end
`ifdef STREAM_CHUNK_PACKER_COUNT_EN
        checks++; if (out_beats !== 3'd2) begin errors++; $display("FAIL partial_beats: got %0d required 2", out_beats); end
`endif
        $display("partial rev: out_data=%h", out_data);
        idle_cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(8'h12, 1'b0, 1'b0);
        send_beat(8'h34, 1'b0, 1'b0);
        send_beat(8'h56, 1'b0, 1'b0);
        send_beat(8'h78, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h9A; in_last = 1'b0; in_rev = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %0b required 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %0b/%h required 1/12345678", c, out_valid, out_data);
            end
            $display("stall cycle %0d: out_data=%h in_ready=%0b", c, out_data, in_ready);
            idle_cycle();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_bypass_ready: got %0b required 1", in_ready); end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b required 0", out_valid); end
        send_beat(8'hBC, 1'b0, 1'b0);
        send_beat(8'hDE, 1'b0, 1'b0);
        send_beat(8'hF0, 1'b0, 1'b0);
        checks++; if (out_data !== 32'h9ABCDEF0) begin errors++; $display("FAIL bp_next_frame: got %h required 9abcdef0", out_data); end
        $display("after backpressure: out_data=%h", out_data);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_last = 1'b1; in_rev = 1'b0; in_data = 8'h5F;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5F000000) begin
            errors++; $display("FAIL b2b_first: got %0b/%h required 1/5f000000", out_valid, out_data);
        end
        $display("b2b frame 1: out_data=%h", out_data);
        in_data = 8'h6E;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h6E000000) begin
            errors++; $display("FAIL b2b_second: got %0b/%h required 1/6e000000", out_valid, out_data);
        end
        $display("b2b frame 2: out_data=%h", out_data);
        in_valid = 1'b0; in_last = 1'b0;
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b required 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        // Reset while a frame is held.
        out_ready = 1'b0;
        send_beat(8'h01, 1'b0, 1'b0);
        send_beat(8'h02, 1'b0, 1'b0);
        send_beat(8'h03, 1'b0, 1'b0);
        send_beat(8'h04, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got %0b/%h required 0/00000000", out_valid, out_data);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_hold_ready: got %0b required 1", in_ready); end
        $display("async reset in hold: out_valid=%0b", out_valid);
        @(posedge clock); #1;
        reset = 1'b0;
        // Reset after two beats of a frame.
        out_ready = 1'b1;
        send_beat(8'hAA, 1'b0, 1'b1);
        send_beat(8'hBB, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %0b required 0", out_valid); end
        reset = 1'b0;
        send_beat(8'h11, 1'b0, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_residue_early: got %0b required 0", out_valid); end
        send_beat(8'h44, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11223344) begin
            errors++; $display("FAIL reset_new_frame: got %0b/%h required 1/11223344", out_valid, out_data);
        end
        $display("post-reset frame: out_data=%h", out_data);
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_reverse();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
